// File: rtl/palette_pkg.sv
// Shared types and helpers for the animated palette lookup.
//   rgb_t      : packed {r,g,b} colour entry, RGB_CH_W bits per channel
//   state_t    : INIT (post-reset clear) / RUN (normal operation)
//   eff_index  : maps a requested palette index to the stored entry,
//                applying palette-cycling rotation inside the animated range
package palette_pkg;

    // Channel width baked into rgb_t; the top-level CH_W must match.
    localparam int unsigned RGB_CH_W = 4;

    typedef struct packed {
        logic [RGB_CH_W-1:0] r;
        logic [RGB_CH_W-1:0] g;
        logic [RGB_CH_W-1:0] b;
    } rgb_t;

    typedef enum logic [0:0] {INIT, RUN} state_t;

    // 32-bit arithmetic leaves headroom when base+len reaches the table depth.
    // offset and phase are both < len, so one conditional subtract is the modulo.
    function automatic int unsigned eff_index(input int unsigned idx,
                                              input int unsigned phase,
                                              input logic        anim_en,
                                              input int unsigned base,
                                              input int unsigned len);
        int unsigned rot;
        if (anim_en && (idx >= base) && (idx < base + len)) begin
            rot = idx - base + phase;
            if (rot >= len) begin
                rot = rot - len;
            end
            return base + rot;
        end
        return idx;
    endfunction

endpackage

// File: rtl/palette_anim_phase.sv
// Frame counter and rotation-phase generator for palette cycling.
//   Clk, Reset  : clock, synchronous active-high reset
//   frame_tick  : one-cycle pulse per video frame
//   anim_en     : cycling enable; low clears counter and phase
//   enable      : qualifies frame_tick (low while the palette is being cleared)
//   anim_phase  : current rotation phase, 0..ANIM_LEN-1
module palette_anim_phase #(
    parameter int unsigned ANIM_LEN        = 3,
    parameter int unsigned FRAMES_PER_STEP = 8,
    parameter int unsigned PHASE_W         = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic               anim_en,
    input  logic               enable,
    output logic [PHASE_W-1:0] anim_phase
);

    localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!anim_en) begin
            cnt_d   = '0;
            phase_d = '0;
        end else if (enable && frame_tick) begin
            if (cnt_q == CNT_W'(FRAMES_PER_STEP - 1)) begin
                cnt_d   = '0;
                phase_d = (phase_q == PHASE_W'(ANIM_LEN - 1)) ? '0 : phase_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign anim_phase = phase_q;

endmodule

// File: rtl/palette_lut_anim.sv
// Runtime-writable multi-bank colour palette with palette cycling.
//   Clk, Reset            : clock, synchronous active-high reset
//   frame_tick, anim_en   : animation phase advance / enable
//   bank_sel, rd_valid,
//   index                 : lookup request; colour appears one cycle later
//   wr_en, wr_bank,
//   wr_index, wr_color    : palette write port ({R,G,B})
//   red, green, blue      : looked-up colour (held when no request)
//   out_valid             : colour belongs to a request issued last cycle
//   init_busy             : high while the post-reset clear sweeps the table
//   anim_phase            : current rotation phase
module palette_lut_anim
    import palette_pkg::*;
#(
    parameter int unsigned INDEX_W         = 4,
    parameter int unsigned NUM_BANKS       = 2,
    parameter int unsigned CH_W            = 4,
    parameter int unsigned ANIM_BASE       = 9,
    parameter int unsigned ANIM_LEN        = 3,
    parameter int unsigned FRAMES_PER_STEP = 8,
    localparam int unsigned BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int unsigned PHASE_W = (ANIM_LEN > 1) ? $clog2(ANIM_LEN) : 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_tick,
    input  logic                anim_en,
    input  logic [BANK_W-1:0]   bank_sel,
    input  logic                rd_valid,
    input  logic [INDEX_W-1:0]  index,
    input  logic                wr_en,
    input  logic [BANK_W-1:0]   wr_bank,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [3*CH_W-1:0]   wr_color,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    output logic                out_valid,
    output logic                init_busy,
    output logic [PHASE_W-1:0]  anim_phase
);

    localparam int unsigned DEPTH    = 2 ** INDEX_W;
    localparam int unsigned PTR_W    = BANK_W + INDEX_W;
    localparam int unsigned LAST_PTR = NUM_BANKS * DEPTH - 1;

    typedef logic [INDEX_W-1:0] idx_t;

    rgb_t mem_q [NUM_BANKS][DEPTH];

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   clr_ptr_q, clr_ptr_d;
    rgb_t               rd_q, rd_d;
    logic               out_valid_q, out_valid_d;

    logic               mem_we;
    logic [BANK_W-1:0]  mem_wbank;
    idx_t               mem_widx;
    rgb_t               mem_wdata;
    idx_t               eff_idx;

    palette_anim_phase #(
        .ANIM_LEN        (ANIM_LEN),
        .FRAMES_PER_STEP (FRAMES_PER_STEP),
        .PHASE_W         (PHASE_W)
    ) u_anim_phase (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .anim_en    (anim_en),
        .enable     (state_q == RUN),
        .anim_phase (anim_phase)
    );

    assign eff_idx = idx_t'(eff_index(32'(index), 32'(anim_phase), anim_en,
                                      ANIM_BASE, ANIM_LEN));

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        rd_d        = rd_q;
        out_valid_d = 1'b0;
        mem_we      = 1'b0;
        mem_wbank   = '0;
        mem_widx    = '0;
        mem_wdata   = '0;
        unique case (state_q)
            INIT: begin
                // Bank-major sweep: upper pointer bits select the bank.
                mem_we    = 1'b1;
                mem_wbank = clr_ptr_q[PTR_W-1:INDEX_W];
                mem_widx  = clr_ptr_q[INDEX_W-1:0];
                if (clr_ptr_q == PTR_W'(LAST_PTR)) begin
                    state_d = RUN;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            RUN: begin
                if (wr_en && (32'(wr_bank) < NUM_BANKS)) begin
                    mem_we    = 1'b1;
                    mem_wbank = wr_bank;
                    mem_widx  = wr_index;
                    mem_wdata = rgb_t'(wr_color);
                end
                // Reads see the pre-edge table, so a same-entry write is not visible yet.
                if (rd_valid) begin
                    out_valid_d = 1'b1;
                    rd_d = (32'(bank_sel) < NUM_BANKS) ? mem_q[bank_sel][eff_idx] : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= INIT;
            clr_ptr_q   <= '0;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Table has no reset; the INIT sweep zeroes it.
    always_ff @(posedge Clk) begin
        if (mem_we && !Reset) begin
            mem_q[mem_wbank][mem_widx] <= mem_wdata;
        end
    end

    assign red       = rd_q.r;
    assign green     = rd_q.g;
    assign blue      = rd_q.b;
    assign out_valid = out_valid_q;
    assign init_busy = (state_q == INIT);

endmodule

// File: doc/palette_lut_anim.md
Name: palette_lut_anim

Overview:
- Runtime-writable, multi-bank colour palette for the sprite/background pixel path.
- Maps a per-pixel palette index to RGB with a registered lookup.
- Adds palette cycling on a configurable index range, e.g. flashing "?" blocks and water shimmer. Phase advances on frame ticks.
- Sits between the tile/sprite index fetch and the VGA colour mux; the software loader writes palettes through a simple write port.

Parameters:
- INDEX_W, 4, palette index width; entries per bank DEPTH = 2**INDEX_W.
- NUM_BANKS, 2, number of selectable palettes (e.g. overworld/underground).
- CH_W, 4, bits per colour channel.
- ANIM_BASE, 9, first animated index.
- ANIM_LEN, 3, number of animated indices; 1..DEPTH-ANIM_BASE. ANIM_LEN=1 disables rotation.
- FRAMES_PER_STEP, 8, frame_tick pulses per animation phase step; >=1.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame (vsync edge).
- anim_en  in  1  enables palette cycling.
- bank_sel  in  max(1,$clog2(NUM_BANKS))  bank used for lookups.
- rd_valid  in  1  lookup request this cycle.
- index  in  INDEX_W  palette index to look up.
- wr_en  in  1  palette write strobe.
- wr_bank  in  max(1,$clog2(NUM_BANKS))  bank to write.
- wr_index  in  INDEX_W  entry to write.
- wr_color  in  3*CH_W  {R,G,B} to store.
- red, green, blue  out  CH_W each  looked-up colour.
- out_valid  out  1  colour outputs correspond to a lookup issued last cycle.
- init_busy  out  1  high while the post-reset clear runs.
- anim_phase  out  max(1,$clog2(ANIM_LEN))  current rotation phase.

Behaviour:
- One clock, Clk. Reset is synchronous and active-high. All state is updated on the rising edge of Clk.
- Reset values: red/green/blue=0, out_valid=0, init_busy=1, anim_phase=0, frame counter=0, FSM=INIT, clear pointer=0.
- FSM INIT:
  - Writes 0 to one entry per cycle, bank-major, over NUM_BANKS*DEPTH cycles.
  - On the cycle the last entry is cleared, moves to RUN; init_busy drops the following cycle.
  - While in INIT, wr_en and rd_valid are ignored, out_valid=0 and colour outputs stay 0.
- FSM RUN: normal operation. Reset asserted in any state, including mid-INIT, restarts INIT from pointer 0.
- Lookup:
  - Latency is 1 cycle: a request with rd_valid=1 in cycle N gives the colour and out_valid=1 in cycle N+1.
  - With rd_valid=0, out_valid=0 next cycle and colour outputs hold their last value.
- Effective index:
  - If anim_en=1 and ANIM_BASE <= index < ANIM_BASE+ANIM_LEN, eff = ANIM_BASE + ((index-ANIM_BASE+anim_phase) mod ANIM_LEN).
  - Otherwise eff = index.
  - bank_sel and anim_phase are sampled in the request cycle.
- Write:
  - wr_en in RUN updates entry [wr_bank][wr_index] at the clock edge.
  - A same-cycle read of the same entry returns the OLD value (read-before-write). The new value is visible to requests in the next cycle.
  - Writes to non-existent banks (wr_bank >= NUM_BANKS) are dropped. Lookups with bank_sel >= NUM_BANKS return 0.
- Animation counter:
  - With anim_en=1, each frame_tick increments the frame counter.
  - When frame_tick arrives with counter=FRAMES_PER_STEP-1, the counter goes to 0 and anim_phase = (anim_phase+1) mod ANIM_LEN (wraps ANIM_LEN-1 -> 0).
  - anim_en=0 synchronously forces counter and anim_phase to 0.
  - frame_tick is ignored in INIT.
- Widths: all modulo arithmetic is done at INDEX_W+1 bits to avoid overflow at ANIM_BASE+ANIM_LEN=DEPTH.

Decomposition:
- Package palette_pkg holds:
  - rgb_t packed struct {r,g,b} of CH_W each;
  - state enum {INIT, RUN};
  - function to compute the effective index.
- Sub-module palette_anim_phase holds the frame counter and phase generator (Clk, Reset, frame_tick, anim_en, enable -> anim_phase).
- Storage is an inferred array of rgb_t with one synchronous read and one write port.

Test Plan:
- Reset, then idle -> init_busy=1 for 32 cycles (defaults). out_valid=0 with rd_valid=1 during INIT. Afterwards any lookup returns 0x000.
- Write bank0 idx0=0x59F and bank1 idx0=0x000, then read idx0 with bank_sel=0 and bank_sel=1 -> 0x59F then 0x000, each out_valid one cycle after request.
- Write idx3=0xFFF while reading idx3 in the same cycle -> old value 0x000. Read the next cycle -> 0xFFF.
- Load idx9=0xC40, idx10=0xF93, idx11=0x000, anim_en=1, 8 frame_ticks -> anim_phase=1 and idx9 reads 0xF93. After 16 more ticks phase wraps 2->0 and idx9 reads 0xC40. idx8 and idx12 stay unaffected throughout.
- anim_en dropped at phase 2 -> anim_phase=0 the next cycle and idx9 reads 0xC40.
- Reset asserted mid-INIT at pointer 10 -> pointer restarts at 0 and init_busy lasts 32 more cycles. Reset in RUN after writes -> all entries read 0 again.
